// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON sequencing controller:
// FSM states, info-byte bit positions and the five 62-bit z sequences.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADK,
        ST_PREROLL,
        ST_LOADB,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam int INFO_OUT = 4;
    localparam int INFO_KEY = 5;
    localparam int INFO_DEC = 6;

    // Leftmost character is z_j[0].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic logic [61:0] z_select(input int n, input int m);
        if (n == 16) return Z0;
        if (n == 24) return (m == 3) ? Z0 : Z1;
        if (n == 32) return (m == 3) ? Z2 : Z3;
        if (n == 48) return (m == 2) ? Z2 : Z3;
        return (m == 2) ? Z2 : ((m == 3) ? Z3 : Z4);
    endfunction

endpackage

// File: rtl/simon_zseq.sv
// Key-schedule constant source: picks z_j for the (N, M) variant and
// emits bit[step], with a modulo-62 step counter that advances on key steps.
module simon_zseq
    import simon_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_step_en,
    input  logic i_clr,
    output logic o_z
);

    localparam logic [61:0] ZSEQ = z_select(N, M);

    logic [5:0] r_step;
    logic [5:0] w_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_step <= '0;
        end else if (i_step_en) begin
            r_step <= (r_step == 6'd61) ? 6'd0 : r_step + 6'd1;
        end
    end

    // Sequence is stored MSB-first, so step k lives at bit 61-k.
    assign w_idx = 6'd61 - r_step;
    assign o_z   = ZSEQ[w_idx];

endmodule

// File: rtl/simon_round_ctrl.sv
// SIMON block sequencer: packet accept, key load, T rounds, result hand-off.
// SIMON_CTRL_DECRYPT_EN adds the PREROLL key walk and honours info[6].
//
// state      | meaning
// IDLE       | wait for doneIN, accept and classify packet
// LOADK      | strobe loadKey, mark key present
// PREROLL    | walk key schedule forward T-M steps before decrypting
// LOADB      | strobe loadBlock, clear round counter
// ROUND      | T round/key steps
// DONE       | restore key, present result until readData
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int Cb = 5,
    parameter logic [3:0] MODE = 4'd0
) (
    input  logic          clk,
    input  logic          R,
    input  logic          doneIN,
    input  logic [7:0]    infoIN,
    output logic          readIN,
    output logic          loadKey,
    output logic          loadBlock,
    output logic          restoreKey,
    output logic          roundEn,
    output logic          keyEn,
    output logic          decrypt,
    output logic [Cb-1:0] round,
    output logic          zBit,
    output logic          doneData,
    input  logic          readData,
    output logic [7:0]    infoOUT,
    output logic [7:0]    countOUT,
    output logic          err
);

    localparam logic [Cb-1:0] LAST = Cb'(T - 1);
`ifdef SIMON_CTRL_DECRYPT_EN
    localparam logic [Cb-1:0] PRE_LAST = Cb'(T - M - 1);
`endif

    state_t        r_state;
    logic [7:0]    r_info;
    logic          r_key_loaded;
    logic [Cb-1:0] r_step;
    logic          w_dec;

`ifdef SIMON_CTRL_DECRYPT_EN
    assign w_dec = r_info[INFO_DEC];
`else
    assign w_dec = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (R) begin
            r_state      <= ST_IDLE;
            r_info       <= '0;
            r_key_loaded <= 1'b0;
            r_step       <= '0;
            readIN       <= 1'b0;
            loadKey      <= 1'b0;
            loadBlock    <= 1'b0;
            restoreKey   <= 1'b0;
            roundEn      <= 1'b0;
            keyEn        <= 1'b0;
            decrypt      <= 1'b0;
            round        <= '0;
            doneData     <= 1'b0;
            infoOUT      <= '0;
            countOUT     <= '0;
            err          <= 1'b0;
        end else begin
            readIN     <= 1'b0;
            loadKey    <= 1'b0;
            loadBlock  <= 1'b0;
            restoreKey <= 1'b0;
            roundEn    <= 1'b0;
            keyEn      <= 1'b0;
            decrypt    <= 1'b0;
            round      <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (doneIN) begin
                        readIN <= 1'b1;
                        r_info <= infoIN;
                        r_step <= '0;
                        if (infoIN[3:0] != MODE) begin
                            err <= 1'b1;
                        end else if (infoIN[INFO_KEY]) begin
                            r_state <= ST_LOADK;
                        end else if (!r_key_loaded) begin
                            err <= 1'b1;
                        end else if (infoIN[INFO_DEC]) begin
`ifdef SIMON_CTRL_DECRYPT_EN
                            r_state <= ST_PREROLL;
`else
                            err <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_LOADB;
                        end
                    end
                end
                ST_LOADK: begin
                    loadKey      <= 1'b1;
                    r_key_loaded <= 1'b1;
                    r_state      <= ST_IDLE;
                end
`ifdef SIMON_CTRL_DECRYPT_EN
                ST_PREROLL: begin
                    // Forward walk leaves the last M round keys in the key register.
                    keyEn  <= 1'b1;
                    r_step <= r_step + 1'b1;
                    if (r_step == PRE_LAST) begin
                        r_step  <= '0;
                        r_state <= ST_LOADB;
                    end
                end
`endif
                ST_LOADB: begin
                    loadBlock <= 1'b1;
                    r_step    <= '0;
                    r_state   <= ST_ROUND;
                end
                ST_ROUND: begin
                    roundEn <= 1'b1;
                    keyEn   <= 1'b1;
                    decrypt <= w_dec;
                    round   <= w_dec ? (LAST - r_step) : r_step;
                    r_step  <= r_step + 1'b1;
                    if (r_step == LAST) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle has doneData still low: that marks entry.
                    if (!doneData) begin
                        restoreKey <= 1'b1;
                        doneData   <= 1'b1;
                        infoOUT    <= {r_info[7:5], 1'b1, r_info[3:0]};
                    end else if (readData) begin
                        doneData <= 1'b0;
                        countOUT <= countOUT + 8'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    simon_zseq #(
        .N(N),
        .M(M)
    ) u_zseq (
        .i_clk    (clk),
        .i_rst    (R),
        .i_step_en(keyEn),
        .i_clr    (loadKey | restoreKey),
        .o_z      (zBit)
    );

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: packet table plus multi-cycle sequences
// (decrypt preroll, DONE hold, count wrap, mid-round reset).
module tb_simon_round_ctrl;

    localparam int T = 32;
    localparam int M = 4;

    logic       clk = 1'b0;
    logic       R = 1'b1;
    logic       doneIN = 1'b0;
    logic [7:0] infoIN = 8'h00;
    logic       readData = 1'b0;
    logic       readIN, loadKey, loadBlock, restoreKey, roundEn, keyEn, decrypt, zBit, doneData, err;
    logic [4:0] round;
    logic [7:0] infoOUT, countOUT;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_rd, cnt_key, cnt_blk, cnt_rk, cnt_done, cnt_pre, cnt_rnd;
    logic       exp_dec = 1'b0;
    logic [7:0] exp_cnt = 8'd0;
    logic [61:0] zref = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef struct {
        logic       do_rst;
        logic [7:0] info;
        logic       e_key;
        logic       e_blk;
        logic       e_done;
        logic       e_err;
        logic [7:0] e_info;
        logic [7:0] e_cnt;
    } vec_t;
    vec_t vt [8];

    simon_round_ctrl dut (
        .clk(clk), .R(R), .doneIN(doneIN), .infoIN(infoIN), .readIN(readIN),
        .loadKey(loadKey), .loadBlock(loadBlock), .restoreKey(restoreKey),
        .roundEn(roundEn), .keyEn(keyEn), .decrypt(decrypt), .round(round),
        .zBit(zBit), .doneData(doneData), .readData(readData),
        .infoOUT(infoOUT), .countOUT(countOUT), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr_cnt();
        cnt_rd = 0; cnt_key = 0; cnt_blk = 0; cnt_rk = 0;
        cnt_done = 0; cnt_pre = 0; cnt_rnd = 0;
    endtask

    task automatic tick();
        int exp_r;
        @(negedge clk);
        if (readIN) cnt_rd++;
        if (loadKey) cnt_key++;
        if (loadBlock) cnt_blk++;
        if (restoreKey) cnt_rk++;
        if (doneData) cnt_done++;
        if (keyEn && !roundEn) begin
            cnt_pre++;
            chk("preroll_dir", decrypt, 1'b0);
        end
        if (roundEn) begin
            exp_r = exp_dec ? (T - 1 - cnt_rnd) : cnt_rnd;
            chk("round_idx", round, exp_r);
            chk("round_dir", decrypt, exp_dec);
            chk("round_keyEn", keyEn, 1'b1);
            if (!exp_dec && cnt_rnd < 62) chk("zBit", zBit, zref[61 - cnt_rnd]);
            cnt_rnd++;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_readIN"}, readIN, 0);
        chk({nm, "_loadKey"}, loadKey, 0);
        chk({nm, "_loadBlock"}, loadBlock, 0);
        chk({nm, "_restoreKey"}, restoreKey, 0);
        chk({nm, "_roundEn"}, roundEn, 0);
        chk({nm, "_keyEn"}, keyEn, 0);
        chk({nm, "_decrypt"}, decrypt, 0);
        chk({nm, "_round"}, round, 0);
        chk({nm, "_doneData"}, doneData, 0);
        chk({nm, "_infoOUT"}, infoOUT, 0);
        chk({nm, "_countOUT"}, countOUT, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        R = 1'b1;
        tick();
        tick();
        R = 1'b0;
        exp_cnt = 8'd0;
        clr_cnt();
    endtask

    task automatic wait_done(output int lat, output logic got);
        lat = 0;
        while (!doneData && lat < 200) begin
            tick();
            lat++;
        end
        got = doneData;
        if (!got) chk("doneData_wait", doneData, 1'b1);
    endtask

    task automatic send_pkt(input logic [7:0] info, input logic want_done,
                            output int lat, output logic got);
        int w;
        clr_cnt();
        exp_dec = info[6];
        lat = 0;
        got = 1'b0;
        doneIN = 1'b1;
        infoIN = info;
        w = 0;
        do begin
            tick();
            w++;
        end while (!readIN && w < 8);
        doneIN = 1'b0;
        if (!readIN) begin
            chk("readIN_wait", readIN, 1'b1);
        end else if (want_done) begin
            wait_done(lat, got);
        end else begin
            repeat (40) tick();
            got = (cnt_done != 0);
        end
    endtask

    task automatic take_result();
        readData = 1'b1;
        tick();
        readData = 1'b0;
        exp_cnt++;
        chk("doneData_clr", doneData, 1'b0);
        chk("countOUT_inc", countOUT, exp_cnt);
    endtask

    initial begin
        int lat;
        int w;
        logic got;
        logic [7:0] start_cnt;

        vt[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd0};
        vt[1] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd0};
        vt[2] = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'd1};
        vt[4] = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'h90, 8'd2};
        vt[5] = '{1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd2};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'd3};
        vt[7] = '{1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'd3};

        clr_cnt();
        tick();
        tick();
        chk_zero("reset");
        R = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vt[i].do_rst) do_reset();
            send_pkt(vt[i].info, vt[i].e_done, lat, got);
            chk("vec_loadKey", cnt_key, vt[i].e_key);
            chk("vec_loadBlock", cnt_blk, vt[i].e_blk);
            chk("vec_done", got, vt[i].e_done);
            if (vt[i].e_done) begin
                chk("vec_latency", lat, T + 2);
                chk("vec_infoOUT", infoOUT, vt[i].e_info);
                chk("vec_restoreKey", cnt_rk, 1);
                chk("vec_rounds", cnt_rnd, T);
                take_result();
            end
            chk("vec_err", err, vt[i].e_err);
            chk("vec_countOUT", countOUT, vt[i].e_cnt);
        end

        // decrypt packet: preroll + reversed rounds, or rejection without the feature
        do_reset();
        send_pkt(8'h20, 1'b0, lat, got);
        chk("dec_keyload", cnt_key, 1);
`ifdef SIMON_CTRL_DECRYPT_EN
        send_pkt(8'h40, 1'b1, lat, got);
        chk("dec_preroll_cycles", cnt_pre, T - M);
        chk("dec_round_cycles", cnt_rnd, T);
        chk("dec_latency", lat, T + 2 + T - M);
        chk("dec_infoOUT", infoOUT, 8'h50);
        take_result();
        chk("dec_err", err, 1'b0);
`else
        send_pkt(8'h40, 1'b0, lat, got);
        chk("dec_err", err, 1'b1);
        chk("dec_noblock", cnt_blk, 0);
        chk("dec_nopre", cnt_pre, 0);
        chk("dec_nodone", got, 1'b0);
        send_pkt(8'h00, 1'b1, lat, got);
        chk("dec_after_latency", lat, T + 2);
        take_result();
`endif

        // readData in IDLE must not move the count
        readData = 1'b1;
        tick();
        readData = 1'b0;
        tick();
        chk("idle_readData_ignored", countOUT, exp_cnt);

        // DONE held with a waiting packet
        send_pkt(8'h00, 1'b1, lat, got);
        chk("hold_latency", lat, T + 2);
        clr_cnt();
        doneIN = 1'b1;
        infoIN = 8'h00;
        repeat (10) begin
            tick();
            chk("hold_doneData", doneData, 1'b1);
        end
        chk("hold_no_readIN", cnt_rd, 0);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        exp_cnt++;
        chk("hold_release_done", doneData, 1'b0);
        chk("hold_release_readIN", readIN, 1'b0);
        chk("hold_release_count", countOUT, exp_cnt);
        tick();
        chk("hold_next_readIN", readIN, 1'b1);
        doneIN = 1'b0;
        wait_done(lat, got);
        chk("hold_next_latency", lat, T + 2);
        take_result();

        // 256 blocks bring the count back to where it started
        start_cnt = countOUT;
        for (int b = 0; b < 256; b++) begin
            send_pkt(8'h00, 1'b1, lat, got);
            take_result();
        end
        chk("wrap_count", countOUT, start_cnt);

        // reset during ROUND cycle 5
        clr_cnt();
        exp_dec = 1'b0;
        doneIN = 1'b1;
        infoIN = 8'h00;
        w = 0;
        do begin
            tick();
            w++;
        end while (!readIN && w < 8);
        doneIN = 1'b0;
        w = 0;
        while (cnt_rnd < 5 && w < 40) begin
            tick();
            w++;
        end
        chk("midrst_reach_round5", cnt_rnd, 5);
        R = 1'b1;
        tick();
        chk_zero("midrst");
        R = 1'b0;
        exp_cnt = 8'd0;
        send_pkt(8'h00, 1'b0, lat, got);
        chk("midrst_key_cleared_err", err, 1'b1);
        chk("midrst_no_block", cnt_blk, 0);
        chk("midrst_no_done", got, 1'b0);
        chk("midrst_count", countOUT, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
